// File: rtl/wb_cmd_pkg.sv
// -----------------------------------------------------------------------------
// wb_cmd_pkg
// Shared definitions for the Wishbone command master: command word field
// positions, op encodings, controller state encoding, the decoded command
// record and a small op classification helper.
// -----------------------------------------------------------------------------
package wb_cmd_pkg;

    // Command word layout: [33:32] op, [31:30] unused, [29:24] address,
    // [23:0] write data.
    localparam int CMD_W    = 34;
    localparam int OP_MSB   = 33;
    localparam int OP_LSB   = 32;
    localparam int ADR_MSB  = 29;
    localparam int ADR_LSB  = 24;
    localparam int WDAT_MSB = 23;
    localparam int WDAT_LSB = 0;

    localparam int ADR_W     = 6;
    localparam int WDAT_W    = 24;
    localparam int DAT_W     = 32;
    localparam int TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_PUSH = 2'b10
    } state_e;

    // A decoded READ/WRITE command as held in the pending slot.
    typedef struct packed {
        logic              we;
        logic [ADR_W-1:0]  adr;
        logic [WDAT_W-1:0] dat;
    } cmd_t;

    // True only for ops that produce a bus cycle; NOP and the reserved
    // encoding are both inert.
    function automatic logic op_is_bus(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/stb_edge_det.sv
// -----------------------------------------------------------------------------
// stb_edge_det
// Rising-edge detector for the command strobe. A strobe held high for
// several cycles yields a single one-cycle pulse.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (clears history)
//   i_stb   in   raw strobe level
//   o_rise  out  high in the first cycle i_stb is seen high
// -----------------------------------------------------------------------------
module stb_edge_det
    import wb_cmd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_stb,
    output logic o_rise
);

    logic r_prev;

    // Remember the strobe level from the previous cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_stb;
        end
    end

    assign o_rise = i_stb & ~r_prev;

endmodule

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
// Turns strobed 34-bit command words into Wishbone classic single cycles.
// WRITE drives {8'h00, data} to the slave; READ captures wb_dat_i on ack and
// pushes it into a downstream FIFO, waiting out fifo_full. One further
// command may be parked in a pending slot while a cycle is in flight; any
// command beyond that is dropped and flagged in the sticky cmd_overflow.
//
// Optional build macro WB_CMD_TIMEOUT_EN: bounds each bus cycle to
// TIMEOUT_CYCLES clocks; on expiry the cycle is abandoned and the sticky
// bus_timeout flag is set. Without the macro the master waits for ack
// indefinitely and bus_timeout is constant 0.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_word[33:0], cmd_stb  command input (accepted on strobe rising edge)
//   wb_cyc_o, wb_stb_o       Wishbone cycle / strobe
//   wb_we_o, wb_adr_o[5:0]   write enable and address
//   wb_dat_o[31:0]           write data
//   wb_sel_o[3:0]            byte selects (all lanes)
//   wb_dat_i[31:0], wb_ack_i read data and acknowledge from slave
//   fifo_din, fifo_wr_en     read data push towards the FIFO
//   fifo_full                FIFO backpressure
//   busy                     transfer in progress or command pending
//   cmd_overflow             sticky: a command was dropped
//   bus_timeout              sticky: a bus cycle timed out
// -----------------------------------------------------------------------------
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd_word,
    input  logic              cmd_stb,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADR_W-1:0]  wb_adr_o,
    output logic [DAT_W-1:0]  wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [DAT_W-1:0]  wb_dat_i,
    input  logic              wb_ack_i,
    output logic [DAT_W-1:0]  fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              busy,
    output logic              cmd_overflow,
    output logic              bus_timeout
);

    state_e             r_state;
    logic               r_cyc;
    logic               r_we;
    logic [ADR_W-1:0]   r_adr;
    logic [WDAT_W-1:0]  r_wdat;
    logic [DAT_W-1:0]   r_rdata;
    logic               r_pend_vld;
    cmd_t               r_pend;
    logic               r_overflow;
    logic               r_busy;

    state_e             w_state_nxt;
    logic               w_cyc_nxt;
    logic               w_we_nxt;
    logic [ADR_W-1:0]   w_adr_nxt;
    logic [WDAT_W-1:0]  w_wdat_nxt;
    logic [DAT_W-1:0]   w_rdata_nxt;
    logic               w_pend_vld_nxt;
    cmd_t               w_pend_nxt;
    logic               w_overflow_nxt;
    logic               w_fifo_wr_en;
    logic               w_issue;
    cmd_t               w_issue_cmd;

    logic               w_rise;
    logic               w_new;
    cmd_t               w_new_cmd;
    logic               w_unused;

`ifdef WB_CMD_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic [TMO_CNT_W-1:0] w_tmo_cnt_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    assign w_unused = ^cmd_word[31:30];
`else
    assign w_unused = ^{cmd_word[31:30], TMO_CNT_W'(TIMEOUT_CYCLES)};
`endif

    stb_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (cmd_stb),
        .o_rise (w_rise)
    );

    // Only READ/WRITE edges count as commands; NOP/reserved are dropped silently.
    assign w_new         = w_rise & op_is_bus(cmd_word[OP_MSB:OP_LSB]);
    assign w_new_cmd.we  = (cmd_word[OP_MSB:OP_LSB] == OP_WRITE);
    assign w_new_cmd.adr = cmd_word[ADR_MSB:ADR_LSB];
    assign w_new_cmd.dat = cmd_word[WDAT_MSB:WDAT_LSB];

    // Next-state, bus register, pending slot and flag computation
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_we_nxt       = r_we;
        w_adr_nxt      = r_adr;
        w_wdat_nxt     = r_wdat;
        w_rdata_nxt    = r_rdata;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        w_overflow_nxt = r_overflow;
        w_fifo_wr_en   = 1'b0;
        w_issue        = 1'b0;
        w_issue_cmd    = r_pend;
`ifdef WB_CMD_TIMEOUT_EN
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_timeout_nxt  = r_timeout;
`endif

        case (r_state)
            ST_IDLE: begin
                // The parked command goes first; a same-cycle newcomer
                // refills the slot so nothing is lost.
                if (r_pend_vld) begin
                    w_issue     = 1'b1;
                    w_issue_cmd = r_pend;
                    if (w_new) begin
                        w_pend_nxt = w_new_cmd;
                    end else begin
                        w_pend_vld_nxt = 1'b0;
                    end
                end else if (w_new) begin
                    w_issue     = 1'b1;
                    w_issue_cmd = w_new_cmd;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wb_ack_i) begin
                    w_cyc_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    if (r_we) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rdata_nxt = wb_dat_i;
                        w_state_nxt = ST_PUSH;
                    end
                end
`ifdef WB_CMD_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    // Abandon the cycle; a timed-out READ has no data to push.
                    w_cyc_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
`else
                else begin
                    w_state_nxt = ST_BUS;
                end
`endif
            end
            ST_PUSH: begin
                // Push decided combinationally so it lands on the very first
                // cycle the FIFO has room.
                if (!fifo_full) begin
                    w_fifo_wr_en = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PUSH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
            end
        endcase

        // While a transfer is active, park one command and drop any further one.
        if ((r_state != ST_IDLE) && w_new) begin
            if (r_pend_vld) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_pend_vld_nxt = 1'b1;
                w_pend_nxt     = w_new_cmd;
            end
        end else begin
            w_overflow_nxt = w_overflow_nxt;
        end

        if (w_issue) begin
            w_state_nxt = ST_BUS;
            w_cyc_nxt   = 1'b1;
            w_we_nxt    = w_issue_cmd.we;
            w_adr_nxt   = w_issue_cmd.adr;
            w_wdat_nxt  = w_issue_cmd.dat;
`ifdef WB_CMD_TIMEOUT_EN
            w_tmo_cnt_nxt = 16'd0;
`endif
        end else begin
            w_cyc_nxt = w_cyc_nxt;
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 6'd0;
            r_wdat     <= 24'd0;
            r_rdata    <= 32'd0;
            r_pend_vld <= 1'b0;
            r_pend     <= '{we: 1'b0, adr: 6'd0, dat: 24'd0};
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_we       <= w_we_nxt;
            r_adr      <= w_adr_nxt;
            r_wdat     <= w_wdat_nxt;
            r_rdata    <= w_rdata_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend     <= w_pend_nxt;
            r_overflow <= w_overflow_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE) || w_pend_vld_nxt;
        end
    end

`ifdef WB_CMD_TIMEOUT_EN
    // Bus-cycle watchdog counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign bus_timeout = r_timeout;
`else
    assign bus_timeout = 1'b0;
`endif

    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_we_o      = r_we;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = {8'h00, r_wdat};
    assign wb_sel_o     = 4'hF;
    assign fifo_din     = r_rdata;
    assign fifo_wr_en   = w_fifo_wr_en;
    assign busy         = r_busy;
    assign cmd_overflow = r_overflow;

endmodule
